mem_bus_router: RTL and testbench
=================================

# mem_bus_router

Parametrised address-decoding router between the Vicuna/Ibex data memory port and N downstream memory-mapped devices (GPIO, timer, SRAM scratch, external storage). It replaces the fixed-map decoder with a mask/base region table, a registered single-outstanding request pipeline, and explicit grant handshakes. It also returns error responses for unmapped, read-only and timed-out accesses. It sits directly on the vproc memory bus; each downstream device sees a local, offset-stripped address.

## Interface
Parameters:
- MEM_W, 32: data bus width in bits, multiple of 8.
- N_DEV, 4: number of downstream device ports, 1..8.
- DEV_BASE, {32'h8000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0100}: packed N_DEV×32 region base addresses; index 0 is the LSB slice.
- DEV_MASK, {32'h8000_0000, 32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_FFF0}: packed N_DEV×32 match masks.
- DEV_RO, 4'b0000: bit i set means device i is read-only.
- TIMEOUT, 255: maximum cycles spent waiting on a device; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_req_i  in  1  upstream request.
- mem_gnt_o  out  1  upstream grant; the request is accepted in the cycle where req&gnt.
- mem_addr_i  in  32  byte address.
- mem_we_i  in  1  write enable.
- mem_be_i  in  MEM_W/8  byte enables.
- mem_wdata_i  in  MEM_W  write data.
- mem_rvalid_o  out  1  one-cycle response pulse, for reads and writes.
- mem_err_o  out  1  error flag, valid with rvalid.
- mem_rdata_o  out  MEM_W  read data, valid with rvalid.
- dev_req_o  out  N_DEV  one-hot device request.
- dev_gnt_i  in  N_DEV  device grant.
- dev_addr_o  out  32  local address, equal to addr & ~DEV_MASK[i]; shared by all devices.
- dev_we_o / dev_be_o / dev_wdata_o  out  1 / MEM_W/8 / MEM_W  shared, registered copies.
- dev_rvalid_i  in  N_DEV  device response.
- dev_err_i  in  N_DEV  device error, valid with rvalid.
- dev_rdata_i  in  N_DEV×MEM_W  packed read data.
- err_cnt_o  out  8  saturating count of error responses.

## Operation
- Region decode: device i matches when (addr & DEV_MASK[i]) == DEV_BASE[i]. The lowest matching index wins. No match means unmapped.
- States:
  - IDLE: mem_gnt_o = mem_req_i. On accept, capture addr, we, be, wdata and the decoded index.
    - Unmapped, or write to a DEV_RO device → go to ERR.
    - Otherwise → go to ISSUE.
  - ISSUE: dev_req_o[idx] = 1, held until dev_gnt_i[idx]. On grant → go to WAIT. Timeout counter runs.
  - WAIT: dev_req_o = 0. On dev_rvalid_i[idx], capture dev_rdata_i slice idx and dev_err_i[idx] → go to RESP. Timeout counter runs.
  - RESP: mem_rvalid_o = 1, mem_rdata_o = captured data, mem_err_o = captured error → go to IDLE.
  - ERR: mem_rvalid_o = 1, mem_err_o = 1, mem_rdata_o = 0 → go to IDLE.
- Timeout:
  - The counter clears on accept and increments in ISSUE and WAIT.
  - When it reaches TIMEOUT (and TIMEOUT != 0) → go to ERR and drop dev_req_o.
- Write responses carry mem_rdata_o = 0.
- dev_rvalid_i from a non-selected device, or in any state other than WAIT, is ignored.
- err_cnt_o increments in each cycle where mem_rvalid_o & mem_err_o. It saturates at 255.
- Only one request is outstanding at a time. mem_gnt_o = 0 in every state except IDLE.

## Timing
- Reset values:
  - State is IDLE.
  - mem_gnt_o=0 while req=0, mem_rvalid_o=0, mem_err_o=0, mem_rdata_o=0.
  - dev_req_o=0, dev_addr_o=0, dev_we_o=0, dev_be_o=0, dev_wdata_o=0.
  - err_cnt_o=0; timeout counter=0.
- Reset mid-transaction aborts immediately. dev_req_o drops in the next cycle and no response is issued.
- Minimum latency (grant and rvalid both zero-wait):
  - Accept at T.
  - dev_req_o at T+1, with dev_gnt_i at T+1.
  - dev_rvalid_i at T+2.
  - mem_rvalid_o at T+3.
- Decode or read-only error: accept at T, mem_rvalid_o with mem_err_o at T+1.
- The next accept is possible in the cycle after mem_rvalid_o.
- dev_* address, control and data outputs are registered. They stay stable from T+1 until the device grants.
- Timeout: mem_rvalid_o with mem_err_o at T+TIMEOUT+2.
- mem_gnt_o is combinational from mem_req_i in IDLE only.

## Test plan
- Read SRAM 0x0000_1004; dev1 grants at once and returns 0xDEADBEEF one cycle later → dev_addr_o=0x004, dev_req_o=4'b0010, mem_rvalid_o at T+3 with rdata 0xDEADBEEF, err=0.
- Read unmapped address 0x0000_0800 → mem_rvalid_o and mem_err_o at T+1, no dev_req_o, err_cnt_o=1.
- With DEV_RO=4'b0010, write 0x0000_1000 → error at T+1 and no dev_req_o. A read to the same address succeeds.
- With TIMEOUT=8, dev3 never grants on a read of 0x8000_0010 → dev_req_o high for 8 cycles, then error at T+10 and dev_req_o=0. A later dev_rvalid_i[3] is ignored.
- Back-to-back writes to 0x0000_0104 then 0x0000_2008, with dev grants delayed 3 cycles → second mem_gnt_o only after the first mem_rvalid_o. dev_addr_o=0x4 then 0x8. Correct be/wdata forwarded.
- Assert rst in WAIT during a read, then inject dev_rvalid_i → no mem_rvalid_o. All outputs at reset values, and a fresh request completes normally.

Source files
------------

// File: rtl/mem_bus_router.sv
// Address-decoding router from the core data port to N memory-mapped devices.
// Single outstanding request; unmapped, read-only and timed-out accesses answer with an error.
module mem_bus_router #(
  parameter int                   MEM_W    = 32,
  parameter int                   N_DEV    = 4,
  parameter logic [N_DEV*32-1:0]  DEV_BASE = {32'h8000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0100},
  parameter logic [N_DEV*32-1:0]  DEV_MASK = {32'h8000_0000, 32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_FFF0},
  parameter logic [N_DEV-1:0]     DEV_RO   = '0,
  parameter int                   TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [31:0]            mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [MEM_W/8-1:0]     mem_be_i,
  input  logic [MEM_W-1:0]       mem_wdata_i,
  output logic                   mem_rvalid_o,
  output logic                   mem_err_o,
  output logic [MEM_W-1:0]       mem_rdata_o,
  output logic [N_DEV-1:0]       dev_req_o,
  input  logic [N_DEV-1:0]       dev_gnt_i,
  output logic [31:0]            dev_addr_o,
  output logic                   dev_we_o,
  output logic [MEM_W/8-1:0]     dev_be_o,
  output logic [MEM_W-1:0]       dev_wdata_o,
  input  logic [N_DEV-1:0]       dev_rvalid_i,
  input  logic [N_DEV-1:0]       dev_err_i,
  input  logic [N_DEV*MEM_W-1:0] dev_rdata_i,
  output logic [7:0]             err_cnt_o
);

  localparam int BE_W  = MEM_W / 8;
  localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_ERR} state_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic             we;
    logic [BE_W-1:0]  be;
    logic [MEM_W-1:0] wdata;
  } dev_cmd_t;

  state_t           r_state;
  dev_cmd_t         r_cmd;
  logic [IDX_W-1:0] r_idx;
  logic [N_DEV-1:0] r_dev_req;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rvalid;
  logic             r_err;
  logic [MEM_W-1:0] r_rdata;
  logic [7:0]       r_err_cnt;

  logic [N_DEV-1:0] w_match;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_local_addr;
  logic             w_ro_err;
  logic [MEM_W-1:0] w_sel_rdata;
  logic             w_to_last;
  logic             w_to_hit;

  for (genvar g = 0; g < N_DEV; g++) begin : g_dec
    assign w_match[g] = (mem_addr_i & DEV_MASK[g*32 +: 32]) == DEV_BASE[g*32 +: 32];
  end

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    w_hit = |w_match;
    w_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--)
      if (w_match[i]) w_idx = IDX_W'(i);
  end

  assign w_local_addr = mem_addr_i & ~DEV_MASK[w_idx*32 +: 32];
  assign w_ro_err     = mem_we_i & DEV_RO[w_idx];
  assign w_sel_rdata  = dev_rdata_i[r_idx*MEM_W +: MEM_W];

  // dev_req_o drops one cycle before the timeout fires so it is held exactly TIMEOUT cycles.
  assign w_to_last = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_to_hit  = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

  assign mem_gnt_o = mem_req_i && (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_idx     <= '0;
      r_dev_req <= '0;
      r_cnt     <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      if (r_rvalid && r_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      case (r_state)
        ST_IDLE: begin
          if (mem_req_i) begin
            r_cnt <= '0;
            if (!w_hit || w_ro_err) begin
              r_state  <= ST_ERR;
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_idx       <= w_idx;
              r_cmd.addr  <= w_local_addr;
              r_cmd.we    <= mem_we_i;
              r_cmd.be    <= mem_be_i;
              r_cmd.wdata <= mem_wdata_i;
              r_dev_req   <= N_DEV'(1) << w_idx;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_to_hit) begin
            r_state   <= ST_ERR;
            r_dev_req <= '0;
            r_rvalid  <= 1'b1;
            r_err     <= 1'b1;
          end else if (dev_gnt_i[r_idx]) begin
            r_state   <= ST_WAIT;
            r_dev_req <= '0;
          end else if (w_to_last) begin
            r_dev_req <= '0;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_to_hit) begin
            r_state  <= ST_ERR;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
          end else if (dev_rvalid_i[r_idx]) begin
            r_state  <= ST_RESP;
            r_rvalid <= 1'b1;
            r_err    <= dev_err_i[r_idx];
            r_rdata  <= r_cmd.we ? '0 : w_sel_rdata;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_rvalid_o = r_rvalid;
  assign mem_err_o    = r_err;
  assign mem_rdata_o  = r_rdata;
  assign dev_req_o    = r_dev_req;
  assign dev_addr_o   = r_cmd.addr;
  assign dev_we_o     = r_cmd.we;
  assign dev_be_o     = r_cmd.be;
  assign dev_wdata_o  = r_cmd.wdata;
  assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_mem_bus_router.sv
// Scoreboard bench for mem_bus_router: directed requests push expected responses,
// a monitor pops and checks each mem_rvalid_o; a small device model answers dev_req_o.
module tb_mem_bus_router;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_gnt_o, mem_we_i, mem_rvalid_o, mem_err_o;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [3:0]  mem_be_i;
  logic [3:0]  dev_req_o, dev_gnt_i, dev_rvalid_i, dev_err_i, dev_be_o;
  logic [31:0] dev_addr_o, dev_wdata_o;
  logic        dev_we_o;
  logic [127:0] dev_rdata_i;
  logic [7:0]  err_cnt_o;

  always #5 clk = ~clk;

  mem_bus_router #(.MEM_W(32), .N_DEV(4), .DEV_RO(4'b0010), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
    .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_err_o(mem_err_o), .mem_rdata_o(mem_rdata_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o),
    .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_err_i(dev_err_i), .dev_rdata_i(dev_rdata_i),
    .err_cnt_o(err_cnt_o)
  );

  typedef struct { logic err; logic [31:0] rdata; int cyc; } exp_t;
  typedef struct { logic [3:0] req; logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } gnt_t;

  exp_t sb[$];
  gnt_t gq[$];
  int total = 0, bad = 0, cyc = 0;

  // device model controls
  logic [31:0] dev_data [4];
  logic [3:0]  dev_errv, no_gnt, hold_rv;
  int          gnt_dly, req_cycles, inject_idx;
  logic        inject_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Device model: grant after gnt_dly waiting cycles, respond on the following cycle.
  initial begin
    int   wait_cnt, pend_idx;
    logic pend_rv;
    wait_cnt = 0; pend_idx = 0; pend_rv = 1'b0;
    dev_gnt_i = '0; dev_rvalid_i = '0; dev_err_i = '0; dev_rdata_i = '0;
    forever begin
      @(negedge clk);
      dev_gnt_i = '0; dev_rvalid_i = '0; dev_err_i = '0; dev_rdata_i = '0;
      if (pend_rv) begin
        dev_rvalid_i[pend_idx] = 1'b1;
        dev_err_i[pend_idx] = dev_errv[pend_idx];
        dev_rdata_i[pend_idx*32 +: 32] = dev_data[pend_idx];
        pend_rv = 1'b0;
      end
      if (inject_rv) begin
        dev_rvalid_i[inject_idx] = 1'b1;
        dev_rdata_i[inject_idx*32 +: 32] = 32'hBAD0_BAD0;
        inject_rv = 1'b0;
      end
      if (dev_req_o != 4'b0) begin
        req_cycles++;
        for (int i = 0; i < 4; i++) begin
          if (dev_req_o[i] && !no_gnt[i]) begin
            if (wait_cnt >= gnt_dly) begin
              dev_gnt_i[i] = 1'b1;
              gq.push_back('{dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o});
              pend_rv = !hold_rv[i];
              pend_idx = i;
              wait_cnt = 0;
            end else wait_cnt++;
          end
        end
      end else wait_cnt = 0;
    end
  end

  // Monitor: every response must match the oldest expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_rvalid_o === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, want none", cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_err", {31'b0, mem_err_o}, {31'b0, e.err});
          chk("resp_rdata", mem_rdata_o, e.rdata);
          chk("resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                       input logic push, input logic e, input logic [31:0] rd, input int lat, output int acc);
    int n;
    @(negedge clk);
    mem_req_i = 1'b1; mem_addr_i = a; mem_we_i = we; mem_be_i = be; mem_wdata_i = wd;
    #1;
    n = 0;
    while (!mem_gnt_o && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) begin
      total++; bad++; acc = -1;
      $display("FAIL accept_timeout: got no grant for addr %h, want grant", a);
    end else begin
      acc = cyc;
      if (push) sb.push_back('{e, rd, cyc + lat});
    end
    @(posedge clk); #1;
    mem_req_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d responses pending, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_gnt"},    {31'b0, mem_gnt_o}, 32'd0);
    chk({t, "_rvalid"}, {31'b0, mem_rvalid_o}, 32'd0);
    chk({t, "_err"},    {31'b0, mem_err_o}, 32'd0);
    chk({t, "_rdata"},  mem_rdata_o, 32'd0);
    chk({t, "_devreq"}, {28'b0, dev_req_o}, 32'd0);
    chk({t, "_devaddr"}, dev_addr_o, 32'd0);
    chk({t, "_devwe"},  {31'b0, dev_we_o}, 32'd0);
    chk({t, "_devbe"},  {28'b0, dev_be_o}, 32'd0);
    chk({t, "_devwdata"}, dev_wdata_o, 32'd0);
    chk({t, "_errcnt"}, {24'b0, err_cnt_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    int acc, acc1, acc2;
    gnt_t g;
    rst = 1'b1; mem_req_i = 1'b0; mem_addr_i = '0; mem_we_i = 1'b0; mem_be_i = '0; mem_wdata_i = '0;
    for (int i = 0; i < 4; i++) dev_data[i] = '0;
    dev_errv = '0; no_gnt = '0; hold_rv = '0; gnt_dly = 0; req_cycles = 0;
    inject_idx = 0; inject_rv = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;

    // SRAM read, zero-wait device
    dev_data[1] = 32'hDEAD_BEEF;
    gq.delete();
    issue(32'h0000_1004, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 3, acc);
    drain();
    chk("t1_grants", gq.size(), 32'd1);
    if (gq.size() > 0) begin
      g = gq.pop_front();
      chk("t1_devaddr", g.addr, 32'h0000_0004);
      chk("t1_devreq", {28'b0, g.req}, 32'h2);
    end

    // unmapped
    req_cycles = 0;
    issue(32'h0000_0800, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0, 1, acc);
    drain();
    chk("t2_noreq", req_cycles, 32'd0);
    chk("t2_errcnt", {24'b0, err_cnt_o}, 32'd1);

    // write to read-only device, then a read that succeeds
    req_cycles = 0;
    issue(32'h0000_1000, 1'b1, 4'hF, 32'h55AA_55AA, 1'b1, 1'b1, 32'h0, 1, acc);
    drain();
    chk("t3_noreq", req_cycles, 32'd0);
    chk("t3_errcnt", {24'b0, err_cnt_o}, 32'd2);
    issue(32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 3, acc);
    drain();

    // timeout on a device that never grants, then a stray response
    no_gnt[3] = 1'b1;
    req_cycles = 0;
    issue(32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0, 10, acc);
    drain();
    chk("t4_reqcycles", req_cycles, 32'd8);
    chk("t4_devreq", {28'b0, dev_req_o}, 32'd0);
    inject_idx = 3; inject_rv = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t4_errcnt", {24'b0, err_cnt_o}, 32'd3);
    no_gnt[3] = 1'b0;

    // back-to-back writes with slow grants
    gnt_dly = 3;
    dev_data[0] = 32'hCAFE_0000; dev_data[2] = 32'h7777_7777;
    gq.delete();
    issue(32'h0000_0104, 1'b1, 4'b0011, 32'h1111_2222, 1'b1, 1'b0, 32'h0, 6, acc1);
    issue(32'h0000_2008, 1'b1, 4'b1100, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'h0, 6, acc2);
    chk("t5_second_accept", acc2, acc1 + 7);
    drain();
    chk("t5_grants", gq.size(), 32'd2);
    if (gq.size() == 2) begin
      g = gq.pop_front();
      chk("t5_g0_req", {28'b0, g.req}, 32'h1);
      chk("t5_g0_addr", g.addr, 32'h4);
      chk("t5_g0_we", {31'b0, g.we}, 32'h1);
      chk("t5_g0_be", {28'b0, g.be}, 32'h3);
      chk("t5_g0_wdata", g.wdata, 32'h1111_2222);
      g = gq.pop_front();
      chk("t5_g1_req", {28'b0, g.req}, 32'h4);
      chk("t5_g1_addr", g.addr, 32'h8);
      chk("t5_g1_be", {28'b0, g.be}, 32'hC);
      chk("t5_g1_wdata", g.wdata, 32'hA5A5_5A5A);
    end
    gnt_dly = 0;

    // device-reported error passes through with its data
    dev_errv[2] = 1'b1; dev_data[2] = 32'h0BAD_F00D;
    issue(32'h0000_2000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0BAD_F00D, 3, acc);
    drain();
    chk("t6_errcnt", {24'b0, err_cnt_o}, 32'd4);
    dev_errv[2] = 1'b0;

    // reset while waiting for the device response
    hold_rv[2] = 1'b1; dev_data[2] = 32'h1234_5678;
    issue(32'h0000_2010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 0, acc);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    inject_idx = 2; inject_rv = 1'b1;
    hold_rv[2] = 1'b0;
    @(negedge clk);
    #1;
    chk_reset("t7");
    @(negedge clk);
    rst = 1'b0;
    issue(32'h0000_2010, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 3, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
